tmr_error_monitor: RTL and testbench

TMR_ERROR_MONITOR -- requirements
Module: tmr_error_monitor

---
 rtl/tmr_error_monitor.sv | 128 ++++++++++++
 tb/tb_tmr_error_monitor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_error_monitor.sv
// Error-event monitor for a bank of TMR majority voters: counts voter disagreement
// events, keeps sticky per-source flags with read-and-clear, and paces scrub pulses.
module tmr_error_monitor #(
  parameter int N_SRC        = 8,
  parameter int CNT_W        = 16,
  parameter int SCRUB_PERIOD = 1024
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic [N_SRC-1:0] tmr_err_i,
  input  logic             rd_req_i,
  output logic             rd_ack_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [N_SRC-1:0] flags_o,
  output logic             ovf_o,
  output logic             irq_o,
  output logic             scrub_o
);

  localparam int POP_W = $clog2(N_SRC + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam int TMR_W = $clog2(SCRUB_PERIOD);
  localparam logic [SUM_W-1:0] CNT_MAX  = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCRUB_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SCRUB} scrubState_t;

  scrubState_t      state, stateNext;
  logic [TMR_W-1:0] timer, timerNext;
  logic [N_SRC-1:0] prevErr;
  logic [N_SRC-1:0] evt;
  logic [POP_W-1:0] evtCount;
  logic [CNT_W-1:0] liveCnt, cntNext, cntBase;
  logic [N_SRC-1:0] liveFlags, flagsNext;
  logic             liveOvf, ovfNext;
  logic [SUM_W-1:0] sum;
  logic             readAccept;

  assign evt        = en_i ? (tmr_err_i & ~prevErr) : '0;
  assign readAccept = rd_req_i & ~rd_ack_o;

  always_comb begin
    evtCount = '0;
    for (int i = 0; i < N_SRC; i++) begin
      evtCount = evtCount + POP_W'(evt[i]);
    end
  end

  // An accepted read restarts the live state from this cycle's events so none are lost.
  always_comb begin
    cntBase   = readAccept ? '0 : liveCnt;
    sum       = SUM_W'(cntBase) + SUM_W'(evtCount);
    ovfNext   = (readAccept ? 1'b0 : liveOvf) | (sum > CNT_MAX);
    cntNext   = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    flagsNext = (readAccept ? '0 : liveFlags) | evt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prevErr   <= '0;
      liveCnt   <= '0;
      liveFlags <= '0;
      liveOvf   <= 1'b0;
      cnt_o     <= '0;
      flags_o   <= '0;
      ovf_o     <= 1'b0;
      rd_ack_o  <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      prevErr   <= tmr_err_i;
      liveCnt   <= cntNext;
      liveFlags <= flagsNext;
      liveOvf   <= ovfNext;
      irq_o     <= |flagsNext;
      rd_ack_o  <= readAccept;
      if (readAccept) begin
        cnt_o   <= liveCnt;
        flags_o <= liveFlags;
        ovf_o   <= liveOvf;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      timer   <= '0;
      scrub_o <= 1'b0;
    end else begin
      state   <= stateNext;
      timer   <= timerNext;
      scrub_o <= (stateNext == SCRUB);
    end
  end

  // Events during SCRUB are not looked at: the reload already in flight covers them.
  always_comb begin
    stateNext = state;
    timerNext = timer;
    case (state)
      IDLE: begin
        timerNext = '0;
        if (en_i) stateNext = WAIT;
      end
      WAIT: begin
        if (!en_i) begin
          stateNext = IDLE;
          timerNext = '0;
        end else if ((timer == TMR_LAST) || (|evt)) begin
          stateNext = SCRUB;
          timerNext = '0;
        end else begin
          timerNext = timer + TMR_W'(1);
        end
      end
      SCRUB: begin
        timerNext = '0;
        stateNext = en_i ? WAIT : IDLE;
      end
      default: begin
        stateNext = IDLE;
        timerNext = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tmr_error_monitor.sv
// Self-checking bench for tmr_error_monitor: directed vector table, multi-cycle
// scrub/reset/saturation sequences, and randomized traffic against a reference model.
module tb_tmr_error_monitor;

  localparam int N_SRC        = 8;
  localparam int CNT_W        = 4;
  localparam int SCRUB_PERIOD = 16;
  localparam int MAX_CNT      = 15;

  logic             clk = 1'b0;
  logic             rstn;
  logic             enIn;
  logic [N_SRC-1:0] errIn;
  logic             rdIn;
  logic             rd_ack_o;
  logic [CNT_W-1:0] cnt_o;
  logic [N_SRC-1:0] flags_o;
  logic             ovf_o;
  logic             irq_o;
  logic             scrub_o;

  tmr_error_monitor #(
    .N_SRC(N_SRC),
    .CNT_W(CNT_W),
    .SCRUB_PERIOD(SCRUB_PERIOD)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .en_i(enIn),
    .tmr_err_i(errIn),
    .rd_req_i(rdIn),
    .rd_ack_o(rd_ack_o),
    .cnt_o(cnt_o),
    .flags_o(flags_o),
    .ovf_o(ovf_o),
    .irq_o(irq_o),
    .scrub_o(scrub_o)
  );

  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;

  // Reference model: integer counter with clamp, flag set, and a scrub phase
  // where -1 means disabled, 0..P-1 counts waiting cycles and P means pulsing.
  logic [7:0] mPrev, mFlags, mSnapFlags;
  int         mCnt, mSnapCnt, mPhase;
  bit         mOvf, mSnapOvf, mAck, mIrq, mScrub;

  typedef struct {
    bit         en;
    logic [7:0] err;
    bit         rd;
    bit         ack;
    int         cnt;
    logic [7:0] flags;
    bit         ovf;
    bit         irq;
    bit         scrub;
  } VecRec;

  VecRec vecTable[18];

  task automatic modelReset();
    mPrev = 8'h00; mFlags = 8'h00; mSnapFlags = 8'h00;
    mCnt = 0; mSnapCnt = 0; mPhase = -1;
    mOvf = 0; mSnapOvf = 0; mAck = 0; mIrq = 0; mScrub = 0;
  endtask

  task automatic modelStep(input bit en, input logic [7:0] err, input bit rd);
    logic [7:0] evt;
    int n;
    evt = en ? (err & ~mPrev) : 8'h00;
    n = $countones(evt);
    mScrub = 0;
    if (mPhase == -1 || mPhase == SCRUB_PERIOD) mPhase = en ? 0 : -1;
    else if (!en) mPhase = -1;
    else if (mPhase == SCRUB_PERIOD - 1 || n > 0) begin
      mPhase = SCRUB_PERIOD;
      mScrub = 1;
    end else mPhase++;
    if (rd && !mAck) begin
      mSnapCnt = mCnt; mSnapFlags = mFlags; mSnapOvf = mOvf;
      mCnt = 0; mFlags = 8'h00; mOvf = 0; mAck = 1;
    end else mAck = 0;
    mCnt = mCnt + n;
    if (mCnt > MAX_CNT) begin
      mCnt = MAX_CNT;
      mOvf = 1;
    end
    mFlags = mFlags | evt;
    mIrq = (mFlags != 8'h00);
    mPrev = err;
  endtask

  task automatic applyStimulus(input bit en, input logic [7:0] err, input bit rd);
    enIn = en; errIn = err; rdIn = rd;
    @(posedge clk);
    modelStep(en, err, rd);
    #1;
  endtask

  task automatic checkOutput(input string tag, input bit ack, input int cnt, input logic [7:0] flags,
                             input bit ovf, input bit irq, input bit scrub);
    vecCount++;
    if (rd_ack_o !== ack || int'(cnt_o) != cnt || flags_o !== flags || ovf_o !== ovf ||
        irq_o !== irq || scrub_o !== scrub) begin
      missCount++;
      $display("[TB] FAIL %s: got ack=%b cnt=%0d flags=%h ovf=%b irq=%b scrub=%b, want ack=%b cnt=%0d flags=%h ovf=%b irq=%b scrub=%b",
               tag, rd_ack_o, cnt_o, flags_o, ovf_o, irq_o, scrub_o, ack, cnt, flags, ovf, irq, scrub);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, mAck, mSnapCnt, mSnapFlags, mSnapOvf, mIrq, mScrub);
  endtask

  task automatic checkValue(input string tag, input int got, input int want);
    vecCount++;
    if (got != want) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lastPulse, dutPulses, modelPulses, firstPulse;
    logic [7:0] rndErr;

    vecTable[0]  = '{1, 8'h00, 0, 0, 0,  8'h00, 0, 0, 0};
    vecTable[1]  = '{1, 8'h04, 0, 0, 0,  8'h00, 0, 1, 1};
    vecTable[2]  = '{1, 8'h04, 0, 0, 0,  8'h00, 0, 1, 0};
    vecTable[3]  = '{1, 8'h04, 0, 0, 0,  8'h00, 0, 1, 0};
    vecTable[4]  = '{1, 8'h20, 0, 0, 0,  8'h00, 0, 1, 1};
    vecTable[5]  = '{1, 8'h00, 1, 1, 2,  8'h24, 0, 0, 0};
    vecTable[6]  = '{1, 8'h00, 1, 0, 2,  8'h24, 0, 0, 0};
    vecTable[7]  = '{1, 8'h01, 1, 1, 0,  8'h00, 0, 1, 1};
    vecTable[8]  = '{1, 8'h00, 0, 0, 0,  8'h00, 0, 1, 0};
    vecTable[9]  = '{1, 8'h00, 1, 1, 1,  8'h01, 0, 0, 0};
    vecTable[10] = '{1, 8'h00, 0, 0, 1,  8'h01, 0, 0, 0};
    vecTable[11] = '{1, 8'hFF, 0, 0, 1,  8'h01, 0, 1, 1};
    vecTable[12] = '{1, 8'hFF, 0, 0, 1,  8'h01, 0, 1, 0};
    vecTable[13] = '{1, 8'h00, 1, 1, 8,  8'hFF, 0, 0, 0};
    vecTable[14] = '{1, 8'hFF, 0, 0, 8,  8'hFF, 0, 1, 1};
    vecTable[15] = '{1, 8'h00, 0, 0, 8,  8'hFF, 0, 1, 0};
    vecTable[16] = '{1, 8'hFF, 0, 0, 8,  8'hFF, 0, 1, 1};
    vecTable[17] = '{1, 8'h00, 1, 1, 15, 8'hFF, 1, 0, 0};

    rstn = 1'b0; enIn = 1'b0; errIn = '0; rdIn = 1'b0;
    modelReset();
    #1;
    checkOutput("resetState", 0, 0, 8'h00, 0, 0, 0);
    #11;
    rstn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecTable[i].en, vecTable[i].err, vecTable[i].rd);
      checkOutput($sformatf("table%0d", i), vecTable[i].ack, vecTable[i].cnt, vecTable[i].flags,
                  vecTable[i].ovf, vecTable[i].irq, vecTable[i].scrub);
    end

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 8'(1 << (i % 8)), 0);
      checkModel("satEvent");
      applyStimulus(1, 8'h00, 0);
      checkModel("satIdle");
    end
    applyStimulus(1, 8'h00, 1);
    checkModel("satRead");
    checkValue("satCnt", int'(cnt_o), 15);
    checkValue("satOvf", int'(ovf_o), 1);
    checkValue("satFlags", int'(flags_o), 8'hFF);

    lastPulse = -1; dutPulses = 0; modelPulses = 0;
    for (int c = 0; c < 60; c++) begin
      applyStimulus(1, 8'h00, 0);
      checkModel("period");
      if (mScrub) modelPulses++;
      if (scrub_o) begin
        dutPulses++;
        if (lastPulse >= 0) checkValue("scrubGap", c - lastPulse, 17);
        lastPulse = c;
      end
    end
    checkValue("periodPulses", dutPulses, modelPulses);

    dutPulses = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(0, 8'h00, 0);
      checkModel("disabled");
      if (scrub_o) dutPulses++;
    end
    checkValue("noScrubDisabled", dutPulses, 0);

    firstPulse = 0;
    for (int c = 1; c <= 40; c++) begin
      applyStimulus(1, 8'h00, 0);
      checkModel("reenable");
      if (scrub_o && firstPulse == 0) firstPulse = c;
    end
    checkValue("reenableFirstPulse", firstPulse, 17);

    applyStimulus(1, 8'h40, 0);
    checkModel("preReset");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 8'h00, 0);
      checkModel("preResetWait");
    end
    applyStimulus(1, 8'h10, 1);
    checkModel("preResetRead");
    errIn = 8'h02; enIn = 1'b0; rdIn = 1'b0;
    rstn = 1'b0;
    #1;
    modelReset();
    checkOutput("resetAsync", 0, 0, 8'h00, 0, 0, 0);
    @(posedge clk);
    #3;
    checkOutput("resetHeld", 0, 0, 8'h00, 0, 0, 0);
    rstn = 1'b1;
    firstPulse = 0;
    for (int c = 1; c <= 40; c++) begin
      applyStimulus(1, 8'h02, 0);
      checkModel("postReset");
      if (scrub_o && firstPulse == 0) firstPulse = c;
    end
    checkValue("postResetFirstPulse", firstPulse, 17);
    checkValue("postResetIrq", int'(irq_o), 1);

    rndErr = 8'h02;
    for (int c = 0; c < 400; c++) begin
      if (c % 57 == 0) rndErr = ~rndErr;
      else rndErr = rndErr ^ 8'($urandom & $urandom & $urandom);
      applyStimulus($urandom_range(0, 9) != 0, rndErr, $urandom_range(0, 4) == 0);
      checkModel("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
